// File: rtl/decrypt_sequencer_if.sv
// Port bundle for decrypt_sequencer: key write port, ciphertext stream, decrypt-stage feed.
// ct stream: a beat transfers on a rising edge where ct_valid & ct_ready; the source holds ct_data stable until then.
interface decrypt_sequencer_if #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 10,
    parameter int AW               = $clog2(DIMENSION + 1)
);
    logic                        key_wr_en;
    logic [AW-1:0]               key_wr_addr;
    logic [CIPHERTEXT_WIDTH-1:0] key_wr_data;
    logic                        key_ready;
    logic                        ct_valid;
    logic [CIPHERTEXT_WIDTH-1:0] ct_data;
    logic                        ct_ready;
    logic [CIPHERTEXT_WIDTH-1:0] secretkey_entry;
    logic [CIPHERTEXT_WIDTH-1:0] ciphertext_entry;
    logic [DIMENSION:0]          row;
    logic                        stream_active;
    logic                        result_valid;
    logic [1:0]                  state_dbg;

    modport master (
        output key_wr_en, key_wr_addr, key_wr_data, ct_valid, ct_data,
        input  key_ready, ct_ready, secretkey_entry, ciphertext_entry, row,
               stream_active, result_valid, state_dbg
    );

    modport slave (
        input  key_wr_en, key_wr_addr, key_wr_data, ct_valid, ct_data,
        output key_ready, ct_ready, secretkey_entry, ciphertext_entry, row,
               stream_active, result_valid, state_dbg
    );
endinterface

// File: rtl/decrypt_sequencer.sv
// Buffers one LWE ciphertext and streams key/ciphertext pairs row by row to the decrypt accumulator.
// Define DECRYPT_SEQ_PINGPONG_EN for two ciphertext buffers (load next while streaming current).
module decrypt_sequencer #(
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 10,
    parameter int AW               = $clog2(DIMENSION + 1)
) (
    input logic           clk,
    input logic           rst_n,
    decrypt_sequencer_if.slave bus
);
    localparam int            N        = DIMENSION + 1;
    localparam int            ROW_W    = DIMENSION + 1;
    localparam logic [AW-1:0] LAST     = AW'(DIMENSION);
    localparam logic [ROW_W-1:0] ROW_IDLE = ROW_W'(DIMENSION);

    typedef enum logic [1:0] {LOAD = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_e;

    state_e                      state_q, state_d;
    logic [AW-1:0]               cnt_q, cnt_d;
    logic [AW-1:0]               scnt_q, scnt_d;
    logic [CIPHERTEXT_WIDTH-1:0] key_q [N];
    logic [CIPHERTEXT_WIDTH-1:0] key_d [N];
    logic                        ct_ready_c, key_ready_c, ct_fire, load_done;
`ifdef DECRYPT_SEQ_PINGPONG_EN
    logic [CIPHERTEXT_WIDTH-1:0] buf_q [2][N];
    logic [CIPHERTEXT_WIDTH-1:0] buf_d [2][N];
    logic [1:0]                  full_q, full_d;
    logic                        wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
`else
    logic [CIPHERTEXT_WIDTH-1:0] buf_q [N];
    logic [CIPHERTEXT_WIDTH-1:0] buf_d [N];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        key_d     = key_q;
        buf_d     = buf_q;
        load_done = 1'b0;
        bus.stream_active    = 1'b0;
        bus.result_valid     = 1'b0;
        bus.secretkey_entry  = '0;
        bus.ciphertext_entry = '0;
        bus.row              = ROW_IDLE;
`ifdef DECRYPT_SEQ_PINGPONG_EN
        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        ct_ready_c  = !full_q[wr_sel_q];
        key_ready_c = (state_q == LOAD) && (cnt_q == '0) && (full_q == 2'b00);
`else
        ct_ready_c  = (state_q == LOAD);
        key_ready_c = (state_q == LOAD) && (cnt_q == '0);
`endif
        ct_fire = bus.ct_valid && ct_ready_c;

        if (ct_fire) begin
`ifdef DECRYPT_SEQ_PINGPONG_EN
            buf_d[wr_sel_q][cnt_q] = bus.ct_data;
`else
            buf_d[cnt_q] = bus.ct_data;
`endif
            if (cnt_q == LAST) begin
                cnt_d     = '0;
                load_done = 1'b1;
`ifdef DECRYPT_SEQ_PINGPONG_EN
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Out-of-range addresses have no key entry and are ignored.
        if (bus.key_wr_en && key_ready_c && (bus.key_wr_addr <= LAST)) begin
            key_d[bus.key_wr_addr] = bus.key_wr_data;
        end

        case (state_q)
            LOAD: begin
`ifdef DECRYPT_SEQ_PINGPONG_EN
                if (full_q[rd_sel_q] || (load_done && (wr_sel_q == rd_sel_q))) state_d = STREAM;
`else
                if (load_done) state_d = STREAM;
`endif
            end
            STREAM: begin
                bus.stream_active   = 1'b1;
                bus.row             = ROW_W'(scnt_q);
                bus.secretkey_entry = key_q[scnt_q];
`ifdef DECRYPT_SEQ_PINGPONG_EN
                bus.ciphertext_entry = buf_q[rd_sel_q][scnt_q];
`else
                bus.ciphertext_entry = buf_q[scnt_q];
`endif
                if (scnt_q == LAST) begin
                    scnt_d  = '0;
                    state_d = DONE;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            DONE: begin
                bus.result_valid = 1'b1;
`ifdef DECRYPT_SEQ_PINGPONG_EN
                // The streamed buffer is released; jump straight to the other one if it is ready.
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                if (full_q[!rd_sel_q] || (load_done && (wr_sel_q != rd_sel_q))) state_d = STREAM;
                else state_d = LOAD;
`else
                state_d = LOAD;
`endif
            end
            default: state_d = LOAD;
        endcase
    end

    assign bus.ct_ready  = ct_ready_c;
    assign bus.key_ready = key_ready_c;
    assign bus.state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            scnt_q  <= '0;
            for (int i = 0; i < N; i++) key_q[i] <= '0;
`ifdef DECRYPT_SEQ_PINGPONG_EN
            full_q   <= 2'b00;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            key_q   <= key_d;
`ifdef DECRYPT_SEQ_PINGPONG_EN
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
`endif
        end
    end

    // Buffer contents need no reset: a partial ciphertext is simply overwritten.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_decrypt_sequencer.sv
// Scoreboard bench for decrypt_sequencer (single-buffer build) with a model of the downstream accumulator.
module tb_decrypt_sequencer;
    localparam int W   = 10;
    localparam int DIM = 10;
    localparam int N   = DIM + 1;
    localparam int AW  = $clog2(N);
    localparam int RW  = DIM + 1;
    localparam int EW  = RW + 2 * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decrypt_sequencer_if #(.CIPHERTEXT_WIDTH(W), .DIMENSION(DIM)) bus ();
    decrypt_sequencer #(.CIPHERTEXT_WIDTH(W), .DIMENSION(DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -100;
    int prev_row_cyc = -100;
    int acc_m = 0;
    logic [EW-1:0] exp_q[$];
    logic [5:0]    res_q[$];
    logic [W-1:0]  key_m [N];
    logic [W-1:0]  ct_m [N];
    logic [EW-1:0] mon_e;
    logic [5:0]    mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected queues whenever the DUT presents a row or a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.stream_active) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL row_unexpected actual row=%0d required=no row", bus.row);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("row", bus.row, mon_e[EW-1 -: RW]);
                    check("secretkey_entry", bus.secretkey_entry, mon_e[2*W-1 -: W]);
                    check("ciphertext_entry", bus.ciphertext_entry, mon_e[W-1:0]);
                    if (bus.row == '0) check("row0_cycle", cyc, last_acc);
                    else check("row_gap", cyc, prev_row_cyc + 1);
                end
                prev_row_cyc = cyc;
                acc_m = ((bus.row == '0) ? 0 : acc_m)
                        + int'(bus.secretkey_entry) * int'(bus.ciphertext_entry);
                acc_m = acc_m & 63;
            end else begin
                check("idle_row", bus.row, DIM);
                check("idle_secretkey_entry", bus.secretkey_entry, 0);
                check("idle_ciphertext_entry", bus.ciphertext_entry, 0);
            end
            if (bus.result_valid) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_unexpected actual result_valid=1 required=0");
                end else begin
                    mon_r = res_q.pop_front();
                    check("result", acc_m, mon_r);
                    check("result_cycle", cyc, last_acc + DIM + 1);
                end
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] d, input int gap);
        int w;
        repeat (gap) @(negedge clk);
        bus.ct_valid = 1'b1;
        bus.ct_data  = d;
        w = 0;
        while (!bus.ct_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL ct_ready_timeout actual ct_ready=0 required=1 within 100 cycles");
        end
        @(posedge clk);
        #1 last_acc = cyc;
        @(negedge clk);
        bus.ct_valid = 1'b0;
        bus.ct_data  = '0;
    endtask

    task automatic send_ct(input int max_gap, input logic [5:0] exp_res);
        for (int r = 0; r < N; r++) exp_q.push_back({RW'(r), key_m[r], ct_m[r]});
        res_q.push_back(exp_res);
        for (int r = 0; r < N; r++) send_beat(ct_m[r], $urandom_range(0, max_gap));
    endtask

    task automatic write_key(input int addr, input logic [W-1:0] data, input logic exp_acc);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_addr = AW'(addr);
        bus.key_wr_data = data;
        check("key_ready", bus.key_ready, exp_acc);
        @(posedge clk);
        @(negedge clk);
        bus.key_wr_en = 1'b0;
        if (exp_acc) key_m[addr] = data;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while ((res_q.size() != 0 || bus.stream_active || bus.result_valid) && w < budget);
        if (w >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual pending=%0d required=0", res_q.size());
        end
    endtask

    task automatic check_reset_vals();
        check("rst_ct_ready", bus.ct_ready, 1);
        check("rst_key_ready", bus.key_ready, 1);
        check("rst_stream_active", bus.stream_active, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_secretkey_entry", bus.secretkey_entry, 0);
        check("rst_ciphertext_entry", bus.ciphertext_entry, 0);
        check("rst_row", bus.row, DIM);
    endtask

    initial begin
        int w;
        bus.key_wr_en   = 1'b0;
        bus.key_wr_addr = '0;
        bus.key_wr_data = '0;
        bus.ct_valid    = 1'b0;
        bus.ct_data     = '0;
        for (int i = 0; i < N; i++) key_m[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic dot product: key all 1, ct 1..11 back-to-back -> 66 mod 64 = 2.
        for (int i = 0; i < N; i++) write_key(i, 10'd1, 1'b1);
        for (int i = 0; i < N; i++) ct_m[i] = W'(i + 1);
        send_ct(0, 6'd2);
        wait_idle(100);

        // Same ciphertext with random gaps; key write during STREAM must be dropped.
        send_ct(3, 6'd2);
        write_key(3, 10'd7, 1'b0);
        // Next ciphertext is presented while the previous still streams (held by ct_ready=0): 11*2 = 22.
        for (int i = 0; i < N; i++) ct_m[i] = 10'd2;
        send_ct(0, 6'd22);
        wait_idle(100);

        // Full-scale entries: 11*1023 = 11253, mod 64 = 53.
        for (int i = 0; i < N; i++) ct_m[i] = 10'd1023;
        send_ct(1, 6'd53);
        wait_idle(100);

        // key[i]=i, ct[i]=i+1: sum i*(i+1) = 440, mod 64 = 56.
        for (int i = 0; i < N; i++) write_key(i, W'(i), 1'b1);
        for (int i = 0; i < N; i++) ct_m[i] = W'(i + 1);
        send_ct(2, 6'd56);
        wait_idle(100);

        // Idle hold: 20 quiet cycles leave the accumulator untouched.
        repeat (20) @(negedge clk);
        check("idle_hold_result", acc_m, 56);

        // Reset at row 5 of a stream.
        send_ct(0, 6'd56);
        w = 0;
        while (!(bus.stream_active && bus.row == RW'(5)) && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("found_row5", (bus.stream_active && bus.row == RW'(5)), 1);
        rst_n = 1'b0;
        exp_q.delete();
        res_q.delete();
        for (int i = 0; i < N; i++) key_m[i] = '0;
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh ciphertext after reset: key file is cleared, so result is 0.
        send_ct(0, 6'd0);
        wait_idle(100);
        check("final_result", acc_m, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
